// File: rtl/ocx_tlx_pkg.sv
// Shared types and constants for the TLX data-flit release controller.
package ocx_tlx_pkg;

    localparam int unsigned MAX_RUN = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned BDI_W   = 8;

    localparam logic BT_RELEASE = 1'b0;
    localparam logic BT_DISCARD = 1'b1;

    typedef struct packed {
        logic             btype;
        logic [CNT_W-1:0] cnt;
        logic [BDI_W-1:0] bdi;
    } batch_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // Service state a freshly popped batch starts in.
    function automatic state_t batch_state(input logic btype);
        return (btype == BT_DISCARD) ? ST_DISCARD : ST_RELEASE;
    endfunction

endpackage

// File: rtl/ocx_tlx_batch_queue.sv
// Small synchronous FIFO of pending release/discard batches.
module ocx_tlx_batch_queue
    import ocx_tlx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  batch_t                       i_push_data,
    input  logic                         i_pop,
    output batch_t                       o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned QC_W  = $clog2(DEPTH + 1);

    batch_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [QC_W-1:0]    r_count;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;

    assign o_full  = (r_count == QC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + QC_W'(1);
                2'b01:   r_count <= r_count - QC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ocx_tlx_data_release_ctl.sv
// Read-side sequencer for the TLX data-flit holding FIFO: counts unverified
// flits, queues bookend/CRC batches, then releases or discards them in order.
module ocx_tlx_data_release_ctl #(
    parameter int unsigned MAX_RUN  = ocx_tlx_pkg::MAX_RUN,
    parameter int unsigned BQ_DEPTH = 4
) (
    input  logic                              tlx_clk,
    input  logic                              reset,
    input  logic                              pars_data_valid,
    input  logic                              bookend_flit_v,
    input  logic [7:0]                        bad_data_indicator,
    input  logic                              crc_error,
    input  logic                              rel_ready,
    output logic                              fifo_rd,
    output logic                              rel_valid,
    output logic                              rel_bad,
    output logic                              rel_last,
    output logic [ocx_tlx_pkg::CNT_W-1:0]     unverif_cnt,
    output logic [$clog2(BQ_DEPTH+1)-1:0]     bq_cnt,
    output logic                              overflow_err
);

    import ocx_tlx_pkg::*;

    localparam int unsigned BQ_CNT_W = $clog2(BQ_DEPTH + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cur_cnt;
    logic [CNT_W-1:0]    w_cur_cnt_nxt;
    logic [BDI_W-1:0]    r_cur_bdi;
    logic [BDI_W-1:0]    w_cur_bdi_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [CNT_W-1:0]    r_unverif;
    logic [CNT_W-1:0]    w_unverif_nxt;
    logic [CNT_W-1:0]    w_run_cnt;
    logic                r_overflow;
    logic                w_sat;
    logic                w_event;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic                w_done;
    logic                w_bq_full;
    logic                w_bq_empty;
    batch_t              w_push_data;
    batch_t              w_bq_head;
    logic [BQ_CNT_W-1:0] w_bq_cnt;

    assign unverif_cnt  = r_unverif;
    assign bq_cnt       = w_bq_cnt;
    assign overflow_err = r_overflow;

    // A flit arriving with a bookend or CRC error belongs to the batch it closes.
    always_comb begin
        w_sat     = pars_data_valid && (r_unverif == CNT_W'(MAX_RUN));
        w_run_cnt = r_unverif;
        if (pars_data_valid && !w_sat) begin
            w_run_cnt = r_unverif + CNT_W'(1);
        end
        w_event           = bookend_flit_v || crc_error;
        w_push            = w_event && (w_run_cnt != '0);
        w_push_data.btype = crc_error ? BT_DISCARD : BT_RELEASE;
        w_push_data.cnt   = w_run_cnt;
        w_push_data.bdi   = bad_data_indicator;
        w_unverif_nxt     = w_event ? '0 : w_run_cnt;
    end

    always_ff @(posedge tlx_clk or posedge reset) begin
        if (reset) begin
            r_unverif  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_unverif <= w_unverif_nxt;
            if (w_sat || (w_push && w_bq_full && !w_pop)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ocx_tlx_batch_queue #(
        .DEPTH (BQ_DEPTH)
    ) u_batch_queue (
        .clk         (tlx_clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_bq_head),
        .o_full      (w_bq_full),
        .o_empty     (w_bq_empty),
        .o_count     (w_bq_cnt)
    );

    // Batch service; finishing a batch loads the next one in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_cnt_nxt = r_cur_cnt;
        w_cur_bdi_nxt = r_cur_bdi;
        w_idx_nxt     = r_idx;
        w_pop         = 1'b0;
        w_done        = 1'b0;
        fifo_rd       = 1'b0;
        rel_valid     = 1'b0;
        rel_bad       = 1'b0;
        rel_last      = 1'b0;
        w_last        = (CNT_W'(r_idx) == (r_cur_cnt - CNT_W'(1)));

        case (r_state)
            ST_IDLE: begin
                w_done = 1'b1;
            end
            ST_RELEASE: begin
                rel_valid = 1'b1;
                rel_bad   = r_cur_bdi[r_idx];
                rel_last  = w_last;
                fifo_rd   = rel_ready;
                if (rel_ready) begin
                    if (w_last) begin
                        w_done = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_DISCARD: begin
                fifo_rd = 1'b1;
                if (w_last) begin
                    w_done = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_done) begin
            if (!w_bq_empty) begin
                w_pop         = 1'b1;
                w_cur_cnt_nxt = w_bq_head.cnt;
                w_cur_bdi_nxt = w_bq_head.bdi;
                w_idx_nxt     = '0;
                w_state_nxt   = batch_state(w_bq_head.btype);
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge tlx_clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cur_cnt <= '0;
            r_cur_bdi <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_cnt <= w_cur_cnt_nxt;
            r_cur_bdi <= w_cur_bdi_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_ocx_tlx_data_release_ctl.sv
// Directed bench: expected per-flit actions kept as a queue and checked every cycle.
module tb_ocx_tlx_data_release_ctl;

    localparam int MAXR = 8;

    logic       tlx_clk            = 1'b0;
    logic       reset              = 1'b1;
    logic       pars_data_valid    = 1'b0;
    logic       bookend_flit_v     = 1'b0;
    logic [7:0] bad_data_indicator = 8'h00;
    logic       crc_error          = 1'b0;
    logic       rel_ready          = 1'b0;
    logic       fifo_rd;
    logic       rel_valid;
    logic       rel_bad;
    logic       rel_last;
    logic [3:0] unverif_cnt;
    logic [2:0] bq_cnt;
    logic       overflow_err;

    ocx_tlx_data_release_ctl #(
        .MAX_RUN  (8),
        .BQ_DEPTH (4)
    ) dut (
        .tlx_clk            (tlx_clk),
        .reset              (reset),
        .pars_data_valid    (pars_data_valid),
        .bookend_flit_v     (bookend_flit_v),
        .bad_data_indicator (bad_data_indicator),
        .crc_error          (crc_error),
        .rel_ready          (rel_ready),
        .fifo_rd            (fifo_rd),
        .rel_valid          (rel_valid),
        .rel_bad            (rel_bad),
        .rel_last           (rel_last),
        .unverif_cnt        (unverif_cnt),
        .bq_cnt             (bq_cnt),
        .overflow_err       (overflow_err)
    );

    always #5 tlx_clk = ~tlx_clk;

    typedef struct {
        logic disc;
        logic bad;
        logic last;
    } act_t;

    act_t m_q[$];
    act_t cmp_h;
    int   m_unv  = 0;
    logic m_ovf  = 1'b0;
    logic m_drop = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cnt_rd = 0;
    int   cnt_hs = 0;
    int   rd0;
    int   hs0;

    logic       obs_rv, obs_bad, obs_last, obs_rd, obs_ovf;
    logic [3:0] obs_unv;
    logic [2:0] obs_bq;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Bookkeeping of what the block must do, from the flit/event rules alone.
    task automatic model_step(input logic pdv, input logic be, input logic [7:0] bdi, input logic crc);
        int n;
        n = m_unv + (pdv ? 1 : 0);
        if (n > MAXR) begin
            n     = MAXR;
            m_ovf = 1'b1;
        end
        if ((be || crc) && n > 0) begin
            if (m_drop) begin
                m_ovf = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    m_q.push_back('{crc, crc ? 1'b0 : bdi[i], (i == n - 1)});
                end
            end
            m_unv = 0;
        end else begin
            m_unv = n;
        end
    endtask

    task automatic cyc(input logic pdv, input logic be, input logic [7:0] bdi,
                       input logic crc, input logic rdy);
        pars_data_valid    = pdv;
        bookend_flit_v     = be;
        bad_data_indicator = bdi;
        crc_error          = crc;
        rel_ready          = rdy;
        #1;
        obs_rv   = rel_valid;
        obs_bad  = rel_bad;
        obs_last = rel_last;
        obs_rd   = fifo_rd;
        obs_unv  = unverif_cnt;
        obs_bq   = bq_cnt;
        obs_ovf  = overflow_err;
        @(posedge tlx_clk);
        model_step(pdv, be, bdi, crc);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic do_reset();
        pars_data_valid = 1'b0;
        bookend_flit_v  = 1'b0;
        crc_error       = 1'b0;
        reset           = 1'b1;
        m_q.delete();
        m_unv = 0;
        m_ovf = 1'b0;
        #1;
        chk("rst_async_outs", {fifo_rd, rel_valid, rel_bad, rel_last, overflow_err}, 0);
        chk("rst_async_unv", unverif_cnt, 0);
        chk("rst_async_bq", bq_cnt, 0);
        @(posedge tlx_clk);
        #1;
        reset = 1'b0;
    endtask

    // Per-cycle comparison against the expected action stream.
    always @(negedge tlx_clk) begin
        if (reset) begin
            chk("rst_outs", {fifo_rd, rel_valid, rel_bad, rel_last, overflow_err}, 0);
            chk("rst_bq", bq_cnt, 0);
        end else begin
            chk("unverif_cnt", unverif_cnt, 32'(m_unv));
            chk("overflow_err", overflow_err, m_ovf);
            if (rel_valid || fifo_rd) begin
                if (m_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious: rel_valid=%0b fifo_rd=%0b, expected no activity at %0t",
                             rel_valid, fifo_rd, $time);
                end else begin
                    cmp_h = m_q[0];
                    if (cmp_h.disc) begin
                        chk("disc_fifo_rd", fifo_rd, 1);
                        chk("disc_rel_valid", rel_valid, 0);
                    end else begin
                        chk("rel_valid", rel_valid, 1);
                        chk("rel_bad", rel_bad, cmp_h.bad);
                        chk("rel_last", rel_last, cmp_h.last);
                        chk("rel_fifo_rd", fifo_rd, rel_ready);
                    end
                    if (fifo_rd) begin
                        void'(m_q.pop_front());
                        cnt_rd++;
                        if (rel_valid) cnt_hs++;
                    end
                end
            end
        end
    end

    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        #1;
        chk("reset_outs", {fifo_rd, rel_valid, rel_bad, rel_last, overflow_err}, 0);
        chk("reset_unv", unverif_cnt, 0);
        chk("reset_bq", bq_cnt, 0);
        @(posedge tlx_clk);
        @(posedge tlx_clk);
        #1;
        reset = 1'b0;

        // Basic release of 3 flits, bdi=02
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        chk("t1_unv_at_bookend", obs_unv, 3);
        idle(1, 1'b1);
        chk("t1_gap_rv", obs_rv, 0);
        chk("t1_unv_cleared", obs_unv, 0);
        idle(1, 1'b1);
        chk("t1_f0", {obs_rv, obs_bad, obs_last, obs_rd}, 4'b1001);
        idle(1, 1'b1);
        chk("t1_f1", {obs_rv, obs_bad, obs_last, obs_rd}, 4'b1101);
        idle(1, 1'b1);
        chk("t1_f2", {obs_rv, obs_bad, obs_last, obs_rd}, 4'b1011);
        idle(1, 1'b1);
        chk("t1_after_rv", obs_rv, 0);
        chk("t1_drained", m_q.size(), 0);

        // CRC discard of 2 flits, then a 1-flit release
        rd0 = cnt_rd; hs0 = cnt_hs;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("t2_disc0", {obs_rv, obs_rd}, 2'b01);
        idle(1, 1'b1);
        chk("t2_disc1", {obs_rv, obs_rd}, 2'b01);
        idle(1, 1'b1);
        chk("t2_rel", {obs_rv, obs_last, obs_rd}, 3'b111);
        idle(2, 1'b1);
        chk("t2_fifo_rd_count", cnt_rd - rd0, 3);
        chk("t2_downstream_count", cnt_hs - hs0, 1);

        // 4-flit release under a toggling ready
        rd0 = cnt_rd;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, pat[i][0]);
            if (i == 2) chk("t3_hold_idx1", {obs_rv, obs_bad, obs_last, obs_rd}, 4'b1100);
            if (i == 5) chk("t3_hold_idx3", {obs_rv, obs_bad, obs_last, obs_rd}, 4'b1110);
        end
        idle(2, 1'b1);
        chk("t3_fifo_rd_count", cnt_rd - rd0, 4);

        // Back-to-back batches behind a stalled 1-flit batch
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        idle(1, 1'b1);
        chk("t4_bq2", obs_bq, 2);
        chk("t4_p", {obs_rv, obs_last}, 2'b11);
        idle(1, 1'b1);
        chk("t4_a0", {obs_rv, obs_bad, obs_last, obs_bq}, {3'b110, 3'd1});
        idle(1, 1'b1);
        chk("t4_a1", {obs_rv, obs_bad, obs_last}, 3'b101);
        idle(1, 1'b1);
        chk("t4_b0", {obs_rv, obs_bad, obs_last, obs_bq}, {3'b111, 3'd0});
        idle(1, 1'b1);
        chk("t4_idle", obs_rv, 0);

        // Bookend and CRC together: the CRC wins
        rd0 = cnt_rd; hs0 = cnt_hs;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("t7_disc", {obs_rv, obs_rd}, 2'b01);
        idle(2, 1'b1);
        chk("t7_fifo_rd_count", cnt_rd - rd0, 2);
        chk("t7_downstream_count", cnt_hs - hs0, 0);

        // Batch-queue overflow and run-length saturation
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) m_drop = 1'b1;
            cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
            m_drop = 1'b0;
            if (i == 3) chk("t5_no_ovf_yet", obs_ovf, 0);
        end
        idle(1, 1'b0);
        chk("t5_bq_full", obs_bq, 4);
        chk("t5_ovf_set", obs_ovf, 1);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("t5_unv_sat", obs_unv, 8);
        chk("t5_ovf_sticky", obs_ovf, 1);
        do_reset();
        idle(1, 1'b0);
        chk("t5_ovf_cleared", obs_ovf, 0);

        // Reset in the middle of a 4-flit release
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1);
        idle(3, 1'b1);
        chk("t6_mid_release", rel_valid, 1);
        do_reset();
        rd0 = cnt_rd;
        idle(6, 1'b1);
        chk("t6_no_rd_after_reset", cnt_rd - rd0, 0);
        chk("t6_bq_empty", obs_bq, 0);
        chk("t6_rv_idle", obs_rv, 0);

        // Bookend with nothing unverified pushes nothing
        cyc(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("t8_bq_empty", obs_bq, 0);
        idle(1, 1'b1);
        chk("t8_rv_idle", obs_rv, 0);

        chk("end_drained", m_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
